// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
//   tx_state_t / rx_state_t : FSM state encodings for the TX and RX paths
//   BIT_IDX_W               : width of the data-bit index (covers up to 9 data bits)
//   cnt_width()             : counter width needed to count one bit period
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int BIT_IDX_W = 4;

    // Counters only ever hold 0..period-1, so $clog2(period) bits suffice.
    function automatic int cnt_width(input int period);
        return (period < 2) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clock cycles and pulses o_tick on the cycle in which
// the count equals i_last (period - 1), then restarts from zero.
//   i_clk   : system clock
//   i_rst   : synchronous active-high reset
//   i_clear : synchronous clear, holds the count at zero
//   i_last  : terminal count (period - 1); may change between periods
//   o_tick  : high for one cycle at the end of each period
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter  int p_PERIOD = 52,
    localparam int W        = cnt_width(p_PERIOD)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic [W-1:0] i_last,
    output logic         o_tick
);

    logic [W-1:0] cnt;

    assign o_tick = (cnt == i_last);

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear || o_tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART datapath: one 8N1-style transmitter and one receiver sharing
// a clock and baud divisor. Frame = start(0), p_WORD_LEN data bits LSB first, stop(1).
//   i_clk, i_rst     : clock, synchronous active-high reset
//   i_send, i_data   : TX request (level) and word, latched when accepted in IDLE
//   o_tx             : registered serial output, idles high
//   o_active, o_done : TX frame in progress / one-cycle completion pulse
//   i_rx             : asynchronous serial input
//   o_data, o_ready  : last good RX word / one-cycle update pulse
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int p_CLK_DIV  = 52,
    parameter int p_WORD_LEN = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_send,
    input  logic [p_WORD_LEN-1:0] i_data,
    output logic                  o_tx,
    output logic                  o_active,
    output logic                  o_done,
    input  logic                  i_rx,
    output logic [p_WORD_LEN-1:0] o_data,
    output logic                  o_ready
);

    localparam int                   c_CW        = cnt_width(p_CLK_DIV);
    localparam logic [c_CW-1:0]      c_FULL_LAST = c_CW'(p_CLK_DIV - 1);
    localparam logic [c_CW-1:0]      c_HALF_LAST = c_CW'(p_CLK_DIV / 2 - 1);
    localparam logic [BIT_IDX_W-1:0] c_LAST_IDX  = BIT_IDX_W'(p_WORD_LEN - 1);

    // ------------------------------------------------------------------ TX
    tx_state_t               tx_state, tx_next;
    logic [p_WORD_LEN-1:0]   tx_shift, tx_shift_n;
    logic [BIT_IDX_W-1:0]    tx_idx, tx_idx_n;
    logic                    tx_tick, tx_clear;
    logic                    tx_d, active_d, done_d;

    uart_bit_timer #(.p_PERIOD(p_CLK_DIV)) u_tx_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (tx_clear),
        .i_last  (c_FULL_LAST),
        .o_tick  (tx_tick)
    );

    // Timer runs only inside a frame so START begins a fresh bit period.
    assign tx_clear = (tx_state == TX_IDLE) || (tx_state == TX_DONE);

    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        tx_next    = tx_state;
        tx_shift_n = tx_shift;
        tx_idx_n   = tx_idx;
        unique case (tx_state)
            TX_IDLE: begin
                if (i_send) begin
                    tx_shift_n = i_data;
                    tx_idx_n   = '0;
                    tx_next    = TX_START;
                end
            end
            TX_START: if (tx_tick) tx_next = TX_DATA;
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift_n = tx_shift >> 1;
                    if (tx_idx == c_LAST_IDX) tx_next  = TX_STOP;
                    else                      tx_idx_n = tx_idx + 1'b1;
                end
            end
            TX_STOP: if (tx_tick) tx_next = TX_DONE;
            TX_DONE: tx_next = TX_IDLE;
            default: tx_next = TX_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so they
        // change on the same edge as the state and never glitch.
        tx_d     = 1'b1;
        if (tx_next == TX_START) tx_d = 1'b0;
        if (tx_next == TX_DATA)  tx_d = tx_shift_n[0];
        active_d = (tx_next == TX_START) || (tx_next == TX_DATA) || (tx_next == TX_STOP);
        done_d   = (tx_next == TX_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            tx_shift <= '0;
            tx_idx   <= '0;
            o_tx     <= 1'b1;
            o_active <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_shift <= tx_shift_n;
            tx_idx   <= tx_idx_n;
            o_tx     <= tx_d;
            o_active <= active_d;
            o_done   <= done_d;
        end
    end

    // ------------------------------------------------------------------ RX
    rx_state_t               rx_state, rx_next;
    logic [p_WORD_LEN-1:0]   rx_shift, rx_shift_n;
    logic [BIT_IDX_W-1:0]    rx_idx, rx_idx_n;
    logic                    rx_meta, rx_sync;
    logic                    rx_tick, rx_clear, rx_load;
    logic [c_CW-1:0]         rx_last;

    // START waits half a bit to land on mid-bit; later periods are full bits.
    // The tick at the end of START wraps the counter, so no clear is needed
    // when the terminal count switches.
    assign rx_last  = (rx_state == RX_START) ? c_HALF_LAST : c_FULL_LAST;
    assign rx_clear = (rx_state == RX_IDLE);

    uart_bit_timer #(.p_PERIOD(p_CLK_DIV)) u_rx_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (rx_clear),
        .i_last  (rx_last),
        .o_tick  (rx_tick)
    );

    always_comb begin
        rx_next    = rx_state;
        rx_shift_n = rx_shift;
        rx_idx_n   = rx_idx;
        rx_load    = 1'b0;
        unique case (rx_state)
            RX_IDLE: if (!rx_sync) rx_next = RX_START;
            RX_START: begin
                if (rx_tick) begin
                    if (rx_sync) begin
                        rx_next = RX_IDLE;      // glitch, not a start bit
                    end else begin
                        rx_idx_n = '0;
                        rx_next  = RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_n = {rx_sync, rx_shift[p_WORD_LEN-1:1]};
                    if (rx_idx == c_LAST_IDX) rx_next  = RX_STOP;
                    else                      rx_idx_n = rx_idx + 1'b1;
                end
            end
            RX_STOP: begin
                // Leave at mid-stop so the next start edge is not missed; a
                // low stop bit is a framing error and the word is dropped.
                if (rx_tick) begin
                    rx_load = rx_sync;
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_shift <= '0;
            rx_idx   <= '0;
            o_data   <= '0;
            o_ready  <= 1'b0;
        end else begin
            rx_meta  <= i_rx;
            rx_sync  <= rx_meta;
            rx_state <= rx_next;
            rx_shift <= rx_shift_n;
            rx_idx   <= rx_idx_n;
            o_ready  <= rx_load;
            if (rx_load) o_data <= rx_shift;
        end
    end

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver (p_CLK_DIV=52, p_WORD_LEN=8).
// Outputs are sampled on the falling clock edge; RX is either looped back from
// o_tx or driven directly by the bench.
module tb_uart_transceiver;

    localparam int CLK_DIV = 52;

    logic       clk = 1'b0;
    logic       i_rst, i_send;
    logic [7:0] i_data;
    logic       o_tx, o_active, o_done, o_ready;
    logic [7:0] o_data;
    logic       loopback, rx_drv, rx_line;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int         done_cnt   = 0;
    int         ready_long = 0;
    logic       ready_prev = 1'b0;

    always #5 clk = ~clk;

    assign rx_line = loopback ? o_tx : rx_drv;

    uart_transceiver #(.p_CLK_DIV(CLK_DIV), .p_WORD_LEN(8)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_send   (i_send),
        .i_data   (i_data),
        .o_tx     (o_tx),
        .o_active (o_active),
        .o_done   (o_done),
        .i_rx     (rx_line),
        .o_data   (o_data),
        .o_ready  (o_ready)
    );

    // Collect received words and completion pulses.
    always @(negedge clk) begin
        if (o_ready) rx_q.push_back(o_data);
        if (o_ready && ready_prev) ready_long++;
        ready_prev = o_ready;
        if (o_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] q_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic wait_done(input int bound);
        int k = 0;
        while (!o_done && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (!o_done) check("done_timeout", 32'(o_done), 32'd1);
    endtask

    // One-cycle send request; returns at the negedge right after acceptance.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        i_data = b;
        i_send = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
    endtask

    task automatic drive_rx_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            rx_drv = bits[j];
            repeat (CLK_DIV) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    logic [7:0] hello [11] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                               8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [9:0] tx_bits;
        int         act_cnt;
        int         first_done;

        i_rst    = 1'b1;
        i_send   = 1'b0;
        i_data   = 8'h00;
        loopback = 1'b1;
        rx_drv   = 1'b1;

        // ---- reset
        repeat (3) @(negedge clk);
        check("rst_tx",     32'(o_tx),     32'd1);
        check("rst_active", 32'(o_active), 32'd0);
        check("rst_done",   32'(o_done),   32'd0);
        check("rst_ready",  32'(o_ready),  32'd0);
        check("rst_data",   32'(o_data),   32'h00);
        i_rst = 1'b0;

        // ---- single frame 0x48, loopback
        rx_q.delete();
        done_cnt   = 0;
        send_byte(8'h48);
        tx_bits    = '0;
        act_cnt    = 0;
        first_done = -1;
        for (int n = 0; n < 600; n++) begin
            if (o_active) act_cnt++;
            if (o_done && first_done < 0) first_done = n;
            if (n % CLK_DIV == CLK_DIV / 2 && n < 10 * CLK_DIV) tx_bits[n / CLK_DIV] = o_tx;
            @(negedge clk);
        end
        check("tx_frame_0x48", 32'(tx_bits),    32'(10'b1010010000));
        check("active_len",    32'(act_cnt),    32'd520);
        check("done_pos",      32'(first_done), 32'd520);
        check("done_count",    32'(done_cnt),   32'd1);
        check("tx_idle",       32'(o_tx),       32'd1);
        check("rx_count_1",    32'(rx_q.size()), 32'd1);
        check("rx_word_1",     32'(q_at(0)),    32'h48);
        check("rx_data_1",     32'(o_data),     32'h48);

        // ---- back-to-back "Hello world", next byte on o_done falling edge
        rx_q.delete();
        done_cnt = 0;
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            i_data = hello[i];
            i_send = 1'b1;
            @(negedge clk);
            i_send = 1'b0;
            wait_done(700);
            @(negedge clk);
        end
        repeat (60) @(negedge clk);
        check("hello_count", 32'(rx_q.size()), 32'd11);
        check("hello_done",  32'(done_cnt),    32'd11);
        for (int i = 0; i < 11; i++) begin
            check($sformatf("hello_%0d", i), 32'(q_at(i)), 32'(hello[i]));
        end

        // ---- busy protection
        rx_q.delete();
        done_cnt = 0;
        send_byte(8'hA5);
        repeat (200) @(negedge clk);
        i_data = 8'h3C;
        i_send = 1'b1;
        @(negedge clk);
        i_send = 1'b0;
        repeat (1000) @(negedge clk);
        check("busy_done",  32'(done_cnt),    32'd1);
        check("busy_count", 32'(rx_q.size()), 32'd1);
        check("busy_word",  32'(q_at(0)),     32'hA5);
        check("busy_idle",  32'(o_active),    32'd0);

        // ---- RX glitch shorter than half a bit
        loopback = 1'b0;
        rx_drv   = 1'b1;
        repeat (5) @(negedge clk);
        rx_q.delete();
        rx_drv = 1'b0;
        repeat (20) @(negedge clk);
        rx_drv = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_count", 32'(rx_q.size()), 32'd0);
        check("glitch_data",  32'(o_data),      32'hA5);

        // ---- framing error: 0x55 with a low stop bit
        drive_rx_frame(8'h55, 1'b0);
        repeat (200) @(negedge clk);
        check("frame_err_count", 32'(rx_q.size()), 32'd0);
        check("frame_err_data",  32'(o_data),      32'hA5);

        // ---- direct good frame still works afterwards
        drive_rx_frame(8'h3C, 1'b1);
        repeat (100) @(negedge clk);
        check("direct_count", 32'(rx_q.size()), 32'd1);
        check("direct_word",  32'(q_at(0)),     32'h3C);

        // ---- reset during data bit 3 of a TX frame
        loopback = 1'b1;
        rx_q.delete();
        done_cnt = 0;
        send_byte(8'h00);
        repeat (230) @(negedge clk);
        check("mid_active", 32'(o_active), 32'd1);
        check("mid_tx_low", 32'(o_tx),     32'd0);
        i_rst = 1'b1;
        @(negedge clk);
        check("abort_tx",     32'(o_tx),     32'd1);
        check("abort_active", 32'(o_active), 32'd0);
        check("abort_data",   32'(o_data),   32'h00);
        i_rst = 1'b0;
        repeat (600) @(negedge clk);
        check("abort_no_done",  32'(done_cnt),    32'd0);
        check("abort_no_ready", 32'(rx_q.size()), 32'd0);

        send_byte(8'hFF);
        wait_done(700);
        repeat (60) @(negedge clk);
        check("ff_count", 32'(rx_q.size()), 32'd1);
        check("ff_word",  32'(q_at(0)),     32'hFF);
        check("ff_done",  32'(done_cnt),    32'd1);
        check("ff_data",  32'(o_data),      32'hFF);

        check("ready_single_cycle", 32'(ready_long), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
Full-duplex UART datapath holding one transmitter and one receiver that share a clock and a baud divisor. The transmitter serialises a parallel word into a standard 8N1-style frame: one start bit, p_WORD_LEN data bits sent LSB first, then one stop bit. The receiver deserialises the same frame format from an asynchronous line. The block sits between the parallel host logic and the serial pins; a loopback of o_tx to i_rx must reproduce the transmitted word.

Parameters:
p_CLK_DIV, 52, clock cycles per bit; integer, must be >= 4.
p_WORD_LEN, 8, data bits per frame; range 5..9.

Ports:
i_clk  in  1  system clock; all logic on the rising edge.
i_rst  in  1  synchronous, active-high reset.
i_send  in  1  TX request; level sampled on each rising edge.
i_data  in  p_WORD_LEN  TX word; latched when a request is accepted.
o_tx  out  1  serial TX line; idles high.
o_active  out  1  high while a TX frame is in progress.
o_done  out  1  one-cycle pulse when a TX frame completes.
i_rx  in  1  asynchronous serial RX line.
o_data  out  p_WORD_LEN  last correctly received word.
o_ready  out  1  one-cycle pulse when o_data is updated.

Behaviour:
- Reset (i_rst high at a clock edge): o_tx=1, o_active=0, o_done=0, o_data=0, o_ready=0, both FSMs go to IDLE, and all counters clear. Reset has priority over everything and aborts any frame in progress.
- TX FSM states: IDLE -> START -> DATA -> STOP -> DONE -> IDLE.
  - IDLE: o_tx=1. If i_send=1, latch i_data and go to START.
  - o_tx is registered, so the line goes low 1 cycle after the accepting edge.
  - START drives 0, DATA drives bit[i] for i=0..p_WORD_LEN-1, STOP drives 1. Each bit lasts exactly p_CLK_DIV cycles, so a frame is (p_WORD_LEN+2)*p_CLK_DIV cycles.
  - o_active=1 throughout START, DATA and STOP; it is 0 in IDLE and DONE.
  - DONE lasts 1 cycle with o_done=1 and o_tx=1, then returns to IDLE.
  - i_send and i_data are ignored outside IDLE; changing i_data mid-frame has no effect on the frame.
  - If i_send is still high in the IDLE cycle after DONE, a new frame starts. Minimum gap between frames is 1 idle cycle plus the DONE cycle.
- RX path: i_rx passes through a 2-flop synchroniser before the FSM.
- RX FSM states: IDLE -> START -> DATA -> STOP -> IDLE.
  - IDLE: wait for the synchronised line to be 0.
  - START: wait p_CLK_DIV/2 cycles (integer division) and re-sample. If the line is 1, it was a glitch: return to IDLE with no output.
  - DATA: sample every p_CLK_DIV cycles at mid-bit, shifting LSB first, p_WORD_LEN samples.
  - STOP: sample after p_CLK_DIV cycles.
    - If the sample is 1, load o_data with the shift register and pulse o_ready for 1 cycle.
    - If the sample is 0 (framing error), leave o_data unchanged and do not pulse o_ready.
  - Either way, return to IDLE immediately after the stop sample (mid-stop-bit), so the next start edge is caught.
- o_data holds its value between frames. o_ready never stays high for more than 1 cycle.
- Counters are sized to $clog2(p_CLK_DIV) bits and do not wrap mid-bit.
- TX and RX are fully independent; simultaneous activity on both is allowed.

Decomposition:
- Package uart_pkg:
  - TX and RX state enums.
  - Bit-index width constant and counter-width function.
- One sub-module, uart_bit_timer: a counter parameterised by period that emits a tick when the count reaches the period, with synchronous clear. It is instantiated once in TX (period p_CLK_DIV) and once in RX (reloaded for half- and full-bit periods).
- The TX and RX FSMs stay in the top level.

Test Plan:
- Reset: hold i_rst 3 cycles -> o_tx=1, o_active=0, o_done=0, o_ready=0, o_data=0x00.
- Single frame, p_CLK_DIV=52, i_data=0x48, 1-cycle i_send pulse:
  - o_tx sequence is 0,0,0,0,1,0,0,1,0,1, each bit 52 cycles.
  - o_active is high for 520 cycles.
  - o_done pulses 1 cycle immediately after.
  - In loopback, o_ready pulses once and o_data=0x48.
- Back-to-back string "Hello world": on each o_done falling edge load the next byte and re-assert i_send -> the RX sequence is 0x48,0x65,0x6C,0x6C,0x6F,0x20,0x77,0x6F,0x72,0x6C,0x64, with no lost or duplicated o_ready.
- Busy protection: start a frame with 0xA5, then pulse i_send and change i_data to 0x3C mid-frame -> exactly one frame is sent, and RX gets 0xA5.
- RX robustness, both cases with RX driven directly:
  - Drive i_rx low for 20 cycles, then high -> no o_ready.
  - Send a frame of 0x55 with the stop bit forced to 0 -> no o_ready and o_data keeps its previous value.
- Reset mid-frame: assert i_rst during DATA bit 3 of a TX frame -> o_tx=1 and o_active=0 on the next cycle, and no o_done pulse. A subsequent 0xFF frame is received correctly.
